// File: rtl/sid_pkg.sv
// Shared definitions for the SID voice blocks: envelope state encoding, register
// offsets, the ADSR rate period table and the exponential decay thresholds.
package sid_pkg;

  typedef enum logic [1:0] {
    ST_ATTACK        = 2'd0,
    ST_DECAY_SUSTAIN = 2'd1,
    ST_RELEASE       = 2'd2
  } env_state_e;

  localparam logic [4:0] OFS_GATE = 5'd4;
  localparam logic [4:0] OFS_AD   = 5'd5;
  localparam logic [4:0] OFS_SR   = 5'd6;

  localparam int unsigned RATE_PERIOD_W = 15;

  // Lower bound of each exponential band; the band below EXP_TH_30 is env == 0.
  localparam logic [7:0] EXP_TH_1  = 8'd94;
  localparam logic [7:0] EXP_TH_2  = 8'd55;
  localparam logic [7:0] EXP_TH_4  = 8'd27;
  localparam logic [7:0] EXP_TH_8  = 8'd15;
  localparam logic [7:0] EXP_TH_16 = 8'd7;
  localparam logic [7:0] EXP_TH_30 = 8'd1;

  function automatic logic [RATE_PERIOD_W-1:0] rate_period(input logic [3:0] idx);
    logic [RATE_PERIOD_W-1:0] p;
    case (idx)
      4'd0:    p = 15'd9;
      4'd1:    p = 15'd32;
      4'd2:    p = 15'd63;
      4'd3:    p = 15'd95;
      4'd4:    p = 15'd149;
      4'd5:    p = 15'd220;
      4'd6:    p = 15'd267;
      4'd7:    p = 15'd313;
      4'd8:    p = 15'd392;
      4'd9:    p = 15'd977;
      4'd10:   p = 15'd1954;
      4'd11:   p = 15'd3126;
      4'd12:   p = 15'd3907;
      4'd13:   p = 15'd11720;
      4'd14:   p = 15'd19532;
      default: p = 15'd31251;
    endcase
    return p;
  endfunction

  function automatic logic [4:0] exp_period(input logic [7:0] env);
    logic [4:0] p;
    if (env >= EXP_TH_1)       p = 5'd1;
    else if (env >= EXP_TH_2)  p = 5'd2;
    else if (env >= EXP_TH_4)  p = 5'd4;
    else if (env >= EXP_TH_8)  p = 5'd8;
    else if (env >= EXP_TH_16) p = 5'd16;
    else if (env >= EXP_TH_30) p = 5'd30;
    else                       p = 5'd1;
    return p;
  endfunction

endpackage

// File: rtl/sid_env_rate.sv
// ADSR rate prescaler: free-running tick counter compared against the selected
// period; issues a one-cycle step pulse on match.
module sid_env_rate
  import sid_pkg::*;
#(
  parameter int unsigned RATE_BITS = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic [3:0] rate_sel,
  output logic       step
);

  logic [RATE_BITS-1:0] cnt_q;
  logic [RATE_BITS-1:0] cnt_d;
  logic [RATE_BITS-1:0] period_m1;

  // The counter is never cleared on a rate change, so a counter already past the
  // new terminal value runs on through the wrap before it can match again.
  always_comb begin
    period_m1 = RATE_BITS'(rate_period(rate_sel)) - RATE_BITS'(1);
    step      = tick && (cnt_q == period_m1);
    cnt_d     = cnt_q;
    if (tick) begin
      cnt_d = step ? '0 : cnt_q + RATE_BITS'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/sid_adsr.sv
// SID ADSR envelope generator: register decode, three-state envelope FSM,
// exponential decay prescaler and the 8-bit envelope level.
module sid_adsr
  import sid_pkg::*;
#(
  parameter logic [4:0]  BASE_ADDR = 5'd0,
  parameter int unsigned RATE_BITS = 15,
  parameter bit          EXP_DECAY = 1'b1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       TICK,
  input  logic       WR,
  input  logic [4:0] ADDR,
  input  logic [7:0] DATA,
  output logic [7:0] OUTPUT,
  output logic [1:0] ENV_STATE
);

  localparam logic [4:0] A_GATE = BASE_ADDR + OFS_GATE;
  localparam logic [4:0] A_AD   = BASE_ADDR + OFS_AD;
  localparam logic [4:0] A_SR   = BASE_ADDR + OFS_SR;

  logic       reg_gate_q, reg_gate_d;
  logic [3:0] att_q, att_d;
  logic [3:0] dec_q, dec_d;
  logic [3:0] sus_q, sus_d;
  logic [3:0] rel_q, rel_d;

  logic       gate_prev_q, gate_prev_d;
  env_state_e state_q, state_d, state_t;
  logic [7:0] env_q, env_d;
  logic [4:0] exp_cnt_q, exp_cnt_d;

  logic       gate_rise;
  logic [3:0] rate_sel;
  logic       step;
  logic [4:0] exp_next;
  logic [4:0] exp_per;
  logic       can_dec;

  always_comb begin
    reg_gate_d = reg_gate_q;
    att_d      = att_q;
    dec_d      = dec_q;
    sus_d      = sus_q;
    rel_d      = rel_q;
    if (WR) begin
      if (ADDR == A_GATE) begin
        reg_gate_d = DATA[0];
      end else if (ADDR == A_AD) begin
        att_d = DATA[7:4];
        dec_d = DATA[3:0];
      end else if (ADDR == A_SR) begin
        sus_d = DATA[7:4];
        rel_d = DATA[3:0];
      end
    end
  end

  // Gate edge first, so the rate for this tick already follows the new state.
  always_comb begin
    gate_prev_d = gate_prev_q;
    gate_rise   = 1'b0;
    state_t     = state_q;
    if (TICK) begin
      gate_prev_d = reg_gate_q;
      if (reg_gate_q && !gate_prev_q) begin
        gate_rise = 1'b1;
        state_t   = ST_ATTACK;
      end else if (!reg_gate_q && gate_prev_q) begin
        state_t = ST_RELEASE;
      end
    end
    case (state_t)
      ST_ATTACK:        rate_sel = att_q;
      ST_DECAY_SUSTAIN: rate_sel = dec_q;
      default:          rate_sel = rel_q;
    endcase
  end

  sid_env_rate #(
    .RATE_BITS (RATE_BITS)
  ) u_rate (
    .clk      (CLK),
    .rst      (RST),
    .tick     (TICK),
    .rate_sel (rate_sel),
    .step     (step)
  );

  always_comb begin
    state_d   = state_t;
    env_d     = env_q;
    exp_cnt_d = exp_cnt_q;
    exp_next  = exp_cnt_q + 5'd1;
    exp_per   = EXP_DECAY ? exp_period(env_q) : 5'd1;
    can_dec   = (state_t == ST_RELEASE) ? (env_q != 8'd0) : (env_q > {sus_q, sus_q});
    if (gate_rise) begin
      exp_cnt_d = '0;
    end
    if (step) begin
      case (state_t)
        ST_ATTACK: begin
          if (env_q == 8'hFF) begin
            state_d = ST_DECAY_SUSTAIN;
          end else begin
            env_d = env_q + 8'd1;
            if (env_q == 8'hFE) state_d = ST_DECAY_SUSTAIN;
          end
        end
        default: begin
          // A raised sustain level only stops the decay; it never pulls env up.
          if (exp_next >= exp_per) begin
            exp_cnt_d = '0;
            if (can_dec) env_d = env_q - 8'd1;
          end else begin
            exp_cnt_d = exp_next;
          end
        end
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      reg_gate_q  <= 1'b0;
      att_q       <= 4'h0;
      dec_q       <= 4'h0;
      sus_q       <= 4'hF;
      rel_q       <= 4'h0;
      gate_prev_q <= 1'b0;
      state_q     <= ST_RELEASE;
      env_q       <= 8'd0;
      exp_cnt_q   <= 5'd0;
    end else begin
      reg_gate_q  <= reg_gate_d;
      att_q       <= att_d;
      dec_q       <= dec_d;
      sus_q       <= sus_d;
      rel_q       <= rel_d;
      gate_prev_q <= gate_prev_d;
      state_q     <= state_d;
      env_q       <= env_d;
      exp_cnt_q   <= exp_cnt_d;
    end
  end

  assign OUTPUT    = env_q;
  assign ENV_STATE = state_q;

endmodule

// File: tb/tb_sid_adsr.sv
// Directed bench for sid_adsr: one exponential and one linear instance share stimulus.
module tb_sid_adsr;

  logic       CLK = 1'b0;
  logic       RST;
  logic       TICK;
  logic       WR;
  logic [4:0] ADDR;
  logic [7:0] DATA;
  logic [7:0] out1, out2;
  logic [1:0] st1, st2;

  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  sid_adsr #(.BASE_ADDR(5'd0), .RATE_BITS(15), .EXP_DECAY(1'b1)) dut_exp (
    .CLK(CLK), .RST(RST), .TICK(TICK), .WR(WR), .ADDR(ADDR), .DATA(DATA),
    .OUTPUT(out1), .ENV_STATE(st1)
  );

  sid_adsr #(.BASE_ADDR(5'd0), .RATE_BITS(15), .EXP_DECAY(1'b0)) dut_lin (
    .CLK(CLK), .RST(RST), .TICK(TICK), .WR(WR), .ADDR(ADDR), .DATA(DATA),
    .OUTPUT(out2), .ENV_STATE(st2)
  );

  function automatic int exp_per(input logic [7:0] v);
    if (v > 8'd93) return 1;
    if (v >= 8'd55) return 2;
    if (v >= 8'd27) return 4;
    if (v >= 8'd15) return 8;
    if (v >= 8'd7) return 16;
    if (v >= 8'd1) return 30;
    return 1;
  endfunction

  task automatic wr(input logic [4:0] a, input logic [7:0] d);
    WR = 1'b1; ADDR = a; DATA = d;
    @(posedge CLK); #1;
    WR = 1'b0;
  endtask

  task automatic tick_n(input int n);
    TICK = 1'b1;
    repeat (n) @(posedge CLK);
    #1;
    TICK = 1'b0;
  endtask

  task automatic do_reset;
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
  endtask

  task automatic test_reset;
    RST = 1'b1;
    #2;
    checks++; if (out1 !== 8'd0) begin errors++; $display("FAIL reset_out: got %0d expected 0", out1); end
    checks++; if (st1 !== 2'd2) begin errors++; $display("FAIL reset_state: got %0d expected 2", st1); end
    checks++; if (st2 !== 2'd2) begin errors++; $display("FAIL reset_state_lin: got %0d expected 2", st2); end
    @(posedge CLK); #1;
    RST = 1'b0;
    tick_n(5);
    checks++; if (st1 !== 2'd2 || out1 !== 8'd0) begin errors++; $display("FAIL reset_idle: got state %0d env %0d expected 2/0", st1, out1); end
  endtask

  task automatic test_attack;
    do_reset();
    wr(5'd5, 8'h00); wr(5'd6, 8'hF0); wr(5'd4, 8'h01);
    tick_n(8);
    checks++; if (out1 !== 8'd0 || st1 !== 2'd0) begin errors++; $display("FAIL attack_pre_step: got env %0d state %0d expected 0/0", out1, st1); end
    tick_n(1);
    checks++; if (out1 !== 8'd1) begin errors++; $display("FAIL attack_first_step: got %0d expected 1", out1); end
    tick_n(2285);
    checks++; if (out1 !== 8'd254 || st1 !== 2'd0) begin errors++; $display("FAIL attack_254: got env %0d state %0d expected 254/0", out1, st1); end
    tick_n(1);
    checks++; if (out1 !== 8'd255 || st1 !== 2'd1) begin errors++; $display("FAIL attack_top: got env %0d state %0d expected 255/1", out1, st1); end
    checks++; if (out2 !== 8'd255 || st2 !== 2'd1) begin errors++; $display("FAIL attack_top_lin: got env %0d state %0d expected 255/1", out2, st2); end
    tick_n(100);
    checks++; if (out1 !== 8'd255 || st1 !== 2'd1) begin errors++; $display("FAIL sustain_f_hold: got env %0d state %0d expected 255/1", out1, st1); end
  endtask

  task automatic test_decay;
    int t, last;
    logic [7:0] prev, want;
    wr(5'd6, 8'h80);
    t = 0; last = -1; prev = out1;
    while (out1 !== 8'h88 && t < 3000) begin
      tick_n(1); t++;
      if (out1 !== prev) begin
        want = prev - 8'd1;
        checks++; if (out1 !== want) begin errors++; $display("FAIL decay_step: got %0d expected %0d", out1, want); end
        if (last >= 0) begin
          checks++; if (t - last != 9) begin errors++; $display("FAIL decay_interval: got %0d ticks expected 9", t - last); end
        end
        last = t; prev = out1;
      end
    end
    checks++; if (out1 !== 8'h88) begin errors++; $display("FAIL decay_level: got %0d expected 136", out1); end
    tick_n(300);
    checks++; if (out1 !== 8'h88 || st1 !== 2'd1) begin errors++; $display("FAIL sustain_hold: got env %0d state %0d expected 136/1", out1, st1); end
    checks++; if (out2 !== 8'h88) begin errors++; $display("FAIL sustain_hold_lin: got %0d expected 136", out2); end
  endtask

  task automatic test_release;
    int t, last, nz;
    logic [7:0] prev, want;
    wr(5'd4, 8'h00);
    tick_n(1);
    checks++; if (st1 !== 2'd2) begin errors++; $display("FAIL release_state: got %0d expected 2", st1); end
    t = 0; last = -1; prev = out1;
    while (out1 !== 8'd0 && t < 8000) begin
      tick_n(1); t++;
      if (out1 !== prev) begin
        want = prev - 8'd1;
        checks++; if (out1 !== want) begin errors++; $display("FAIL release_step: got %0d expected %0d", out1, want); end
        if (last >= 0) begin
          checks++;
          if (t - last != 9 * exp_per(prev)) begin
            errors++; $display("FAIL release_interval env=%0d: got %0d ticks expected %0d", prev, t - last, 9 * exp_per(prev));
          end
        end
        last = t; prev = out1;
      end
    end
    checks++; if (out1 !== 8'd0) begin errors++; $display("FAIL release_floor: got %0d expected 0", out1); end
    nz = 0;
    for (int i = 0; i < 10000; i++) begin
      tick_n(1);
      if (out1 !== 8'd0) nz++;
    end
    checks++; if (nz != 0) begin errors++; $display("FAIL release_no_wrap: got %0d nonzero ticks expected 0", nz); end
    checks++; if (st1 !== 2'd2 || out2 !== 8'd0) begin errors++; $display("FAIL release_end: got state %0d lin env %0d expected 2/0", st1, out2); end
  endtask

  task automatic test_exp_off;
    do_reset();
    wr(5'd5, 8'h00); wr(5'd6, 8'hF0); wr(5'd4, 8'h01);
    tick_n(2295);
    checks++; if (out2 !== 8'd255) begin errors++; $display("FAIL lin_attack_top: got %0d expected 255", out2); end
    wr(5'd4, 8'h00);
    tick_n(2294);
    checks++; if (out2 !== 8'd1 || st2 !== 2'd2) begin errors++; $display("FAIL lin_release_last: got env %0d state %0d expected 1/2", out2, st2); end
    tick_n(1);
    checks++; if (out2 !== 8'd0) begin errors++; $display("FAIL lin_release_zero: got %0d expected 0", out2); end
    checks++; if (out1 !== 8'd51) begin errors++; $display("FAIL exp_release_same_time: got %0d expected 51", out1); end
  endtask

  task automatic test_delay_bug;
    do_reset();
    wr(5'd5, 8'hF0); wr(5'd6, 8'hF0); wr(5'd4, 8'h01);
    tick_n(20000);
    checks++; if (out1 !== 8'd0 || st1 !== 2'd0) begin errors++; $display("FAIL delay_pre: got env %0d state %0d expected 0/0", out1, st1); end
    wr(5'd5, 8'h00);
    tick_n(12776);
    checks++; if (out1 !== 8'd0) begin errors++; $display("FAIL delay_no_early_step: got %0d expected 0", out1); end
    tick_n(1);
    checks++; if (out1 !== 8'd1) begin errors++; $display("FAIL delay_wrap_step: got %0d expected 1", out1); end
  endtask

  task automatic test_gate_pulse;
    do_reset();
    wr(5'd4, 8'h01); wr(5'd4, 8'h00);
    tick_n(1);
    checks++; if (st1 !== 2'd2) begin errors++; $display("FAIL gate_glitch: got %0d expected 2", st1); end
    wr(5'd4, 8'h01);
    tick_n(1);
    checks++; if (st1 !== 2'd0) begin errors++; $display("FAIL gate_rise: got %0d expected 0", st1); end
    wr(5'd4, 8'h00);
    tick_n(1);
    checks++; if (st1 !== 2'd2 || out1 !== 8'd0) begin errors++; $display("FAIL gate_fall: got state %0d env %0d expected 2/0", st1, out1); end
    WR = 1'b1; ADDR = 5'd4; DATA = 8'h01; TICK = 1'b1;
    @(posedge CLK); #1;
    WR = 1'b0; TICK = 1'b0;
    checks++; if (st1 !== 2'd2) begin errors++; $display("FAIL same_cycle_old_gate: got %0d expected 2", st1); end
    tick_n(1);
    checks++; if (st1 !== 2'd0) begin errors++; $display("FAIL same_cycle_next_tick: got %0d expected 0", st1); end
  endtask

  task automatic test_reset_mid;
    do_reset();
    wr(5'd5, 8'h00); wr(5'd6, 8'h30); wr(5'd4, 8'h01);
    tick_n(576);
    checks++; if (out1 !== 8'h40 || st1 !== 2'd0) begin errors++; $display("FAIL mid_attack: got env %0d state %0d expected 64/0", out1, st1); end
    #2;
    RST = 1'b1;
    #1;
    checks++; if (out1 !== 8'd0 || st1 !== 2'd2) begin errors++; $display("FAIL async_reset: got env %0d state %0d expected 0/2", out1, st1); end
    @(posedge CLK); #1;
    RST = 1'b0;
    tick_n(18);
    checks++; if (out1 !== 8'd0 || st1 !== 2'd2) begin errors++; $display("FAIL gate_cleared: got env %0d state %0d expected 0/2", out1, st1); end
    wr(5'd4, 8'h01);
    tick_n(2295);
    checks++; if (out1 !== 8'd255 || st1 !== 2'd1) begin errors++; $display("FAIL att_reset_value: got env %0d state %0d expected 255/1", out1, st1); end
    tick_n(50);
    checks++; if (out1 !== 8'd255) begin errors++; $display("FAIL sus_reset_value: got %0d expected 255", out1); end
  endtask

  initial begin
    RST = 1'b1; TICK = 1'b0; WR = 1'b0; ADDR = 5'd0; DATA = 8'd0;
    test_reset();
    test_attack();
    test_decay();
    test_release();
    test_exp_off();
    test_delay_bug();
    test_gate_pulse();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
